// File: rtl/disp_pkg.sv
// Shared types and widths for the register display scanner.
package disp_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_CAP  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/step_sync_edge.sv
// Push-button conditioner: 2-flop synchronizer plus registered rising-edge
// detector. A held button yields a single one-cycle pulse, 3 edges after the
// button rises.
//   clk_i   : system clock
//   rst_ni  : synchronous active-low reset
//   btn_i   : raw button, asynchronous to clk_i
//   pulse_o : one-cycle pulse per rising edge of btn_i
module step_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    // Synchronizer chain, previous-value flop and registered edge pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/reg_display_scanner.sv
// Scans the register file and shadows one register for five hex displays.
//   Clock/Resetn      : clock, synchronous active-low reset
//   Auto              : 1 = advance index on dwell expiry, 0 = refresh only
//   Step              : raw push-button, advances index once per press
//   Freeze            : hold display, pause dwell, ignore Step
//   RdAddr/RdEn       : register-file read request (one-cycle strobe)
//   RdData            : register-file data, valid the cycle after RdEn
//   Nib3..Nib0        : shadow value nibbles, MSB first
//   IdxNib            : current register index
//   Valid             : set after the first capture
module reg_display_scanner
    import disp_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned DWELL  = 50000000
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Auto,
    input  logic              Step,
    input  logic              Freeze,
    output logic [IDX_W-1:0]  RdAddr,
    output logic              RdEn,
    input  logic [DATA_W-1:0] RdData,
    output logic [NIB_W-1:0]  Nib3,
    output logic [NIB_W-1:0]  Nib2,
    output logic [NIB_W-1:0]  Nib1,
    output logic [NIB_W-1:0]  Nib0,
    output logic [NIB_W-1:0]  IdxNib,
    output logic              Valid
);

    localparam int unsigned     CNT_W    = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(NREGS - 1);

    state_e              state_q,  state_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic                valid_q,  valid_d;
    logic                rd_en_q,  rd_en_d;
    logic [IDX_W-1:0]    rd_addr_q, rd_addr_d;
    logic                step_pulse;

    step_sync_edge u_step (
        .clk_i   (Clock),
        .rst_ni  (Resetn),
        .btn_i   (Step),
        .pulse_o (step_pulse)
    );

    // State and datapath registers.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q   <= S_REQ;
            idx_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            valid_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            valid_q   <= valid_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Next-state logic. Priority in S_HOLD: Freeze, then step, then dwell expiry.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        valid_d  = valid_q;
        unique case (state_q)
            // The strobe is raised on entry; after reset the first S_REQ
            // cycle issues it, and the state moves on once it is out.
            S_REQ: begin
                if (rd_en_q) begin
                    state_d = S_CAP;
                end
            end
            S_CAP: begin
                shadow_d = RdData;
                valid_d  = 1'b1;
                cnt_d    = '0;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                if (!Freeze) begin
                    if (step_pulse) begin
                        idx_d   = IDX_W'(idx_q + 1'b1) & IDX_MASK;
                        state_d = S_REQ;
                    end else if (cnt_q == CNT_LAST) begin
                        if (Auto) begin
                            idx_d = IDX_W'(idx_q + 1'b1) & IDX_MASK;
                        end
                        state_d = S_REQ;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + 1'b1);
                    end
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
        // Registered strobe is high exactly during the S_REQ cycle.
        rd_en_d   = (state_d == S_REQ) && !rd_en_q;
        rd_addr_d = idx_d;
    end

    assign RdEn   = rd_en_q;
    assign RdAddr = rd_addr_q;
    assign Valid  = valid_q;
    assign Nib3   = shadow_q[4*NIB_W-1 -: NIB_W];
    assign Nib2   = shadow_q[3*NIB_W-1 -: NIB_W];
    assign Nib1   = shadow_q[2*NIB_W-1 -: NIB_W];
    assign Nib0   = shadow_q[NIB_W-1 -: NIB_W];
    assign IdxNib = {{(NIB_W-IDX_W){1'b0}}, idx_q};

endmodule

// File: tb/tb_reg_display_scanner.sv
// Scoreboard bench: stimulus pushes expected reads, a monitor checks each
// read request and the display values two cycles later.
module tb_reg_display_scanner;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Auto = 1'b1;
    logic        Step = 1'b0;
    logic        Freeze = 1'b0;
    logic [2:0]  RdAddr;
    logic        RdEn;
    logic [15:0] RdData = 16'h0;
    logic [3:0]  Nib3, Nib2, Nib1, Nib0, IdxNib;
    logic        Valid;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] data;
        bit          from_mark;
        int          gap;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem[8];
    int          cyc = 0;
    int          mark_cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          dropped = 0;
    bit          mon_busy = 1'b0;

    reg_display_scanner #(.DATA_W(16), .NREGS(8), .DWELL(4)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Auto   (Auto),
        .Step   (Step),
        .Freeze (Freeze),
        .RdAddr (RdAddr),
        .RdEn   (RdEn),
        .RdData (RdData),
        .Nib3   (Nib3),
        .Nib2   (Nib2),
        .Nib1   (Nib1),
        .Nib0   (Nib0),
        .IdxNib (IdxNib),
        .Valid  (Valid)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Registered register-file read port.
    always @(posedge Clock) begin
        if (RdEn) RdData <= mem[RdAddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [2:0] idx, input logic [15:0] data,
                        input bit from_mark, input int gap);
        exp_t e;
        e.idx = idx; e.data = data; e.from_mark = from_mark; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size()) + 32'(mon_busy), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_rden(input int budget);
        int n = 0;
        while (RdEn !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("rden_wait", 32'(RdEn), 32'd1);
    endtask

    task automatic reset_dut(input bit do_chk);
        Resetn = 1'b0;
        repeat (3) tick();
        if (do_chk) begin
            chk("rst_valid", 32'(Valid), 32'd0);
            chk("rst_rden", 32'(RdEn), 32'd0);
            chk("rst_rdaddr", 32'(RdAddr), 32'd0);
            chk("rst_nibs", {16'h0, Nib3, Nib2, Nib1, Nib0}, 32'd0);
            chk("rst_idxnib", 32'(IdxNib), 32'd0);
        end
        Resetn = 1'b1;
        mark_cyc = cyc;
    endtask

    // Monitor: on each read strobe, check address and spacing, then the
    // display two cycles later unless a reset intervened.
    initial begin
        exp_t e;
        int   prev_rd;
        prev_rd = 0;
        forever begin
            @(negedge Clock);
            if (Resetn === 1'b1 && RdEn === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_read", 32'(RdEn), 32'd0);
                end else begin
                    mon_busy = 1'b1;
                    e = exp_q.pop_front();
                    chk("rd_addr", 32'(RdAddr), 32'(e.idx));
                    if (e.gap != 0)
                        chk("rd_gap", 32'(cyc - (e.from_mark ? mark_cyc : prev_rd)), 32'(e.gap));
                    prev_rd = cyc;
                    @(negedge Clock);
                    if (Resetn === 1'b1) chk("rden_one_cycle", 32'(RdEn), 32'd0);
                    @(negedge Clock);
                    if (Resetn !== 1'b1) begin
                        dropped++;
                    end else begin
                        chk("valid", 32'(Valid), 32'd1);
                        chk("nibs", {16'h0, Nib3, Nib2, Nib1, Nib0}, {16'h0, e.data});
                        chk("idx_nib", 32'(IdxNib), {29'h0, e.idx});
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int freeze_reads;
        for (int k = 0; k < 8; k++) mem[k] = 16'(16'h1111 * k);

        // Auto scan with wrap 0..7 then 0.
        Auto = 1'b1;
        reset_dut(1'b1);
        push(3'd0, 16'h0000, 1'b1, 1);
        for (int k = 1; k < 8; k++) push(3'(k), 16'(16'h1111 * k), 1'b0, 6);
        push(3'd0, 16'h0000, 1'b0, 6);
        wait_done(120, "auto_wrap_done");

        // Manual mode: live refresh of R0, then a long Step press.
        Auto = 1'b0;
        reset_dut(1'b0);
        push(3'd0, 16'h0000, 1'b1, 1);
        push(3'd0, 16'h0000, 1'b0, 6);
        push(3'd0, 16'h0000, 1'b0, 6);
        wait_done(40, "manual_refresh_done");
        mem[0] = 16'hBEEF;
        push(3'd0, 16'hBEEF, 1'b0, 6);
        found = 1'b0;
        for (int i = 0; i < 7 && !found; i++) begin
            tick();
            if ({Nib3, Nib2, Nib1, Nib0} == 16'hBEEF) found = 1'b1;
        end
        chk("beef_within_7", 32'(found), 32'd1);
        wait_done(20, "beef_done");
        push(3'd0, 16'hBEEF, 1'b0, 6);
        wait_rden(20);
        Step = 1'b1;
        push(3'd1, 16'h1111, 1'b0, 4);
        repeat (3) push(3'd1, 16'h1111, 1'b0, 6);
        wait_done(40, "step_hold_done");
        Step = 1'b0;
        chk("step_one_advance", 32'(IdxNib), 32'd1);

        // Freeze at dwell count 2 with Step toggling.
        mem[0] = 16'h0000;
        Auto = 1'b1;
        reset_dut(1'b0);
        push(3'd0, 16'h0000, 1'b1, 1);
        push(3'd1, 16'h1111, 1'b0, 6);
        wait_done(40, "pre_freeze_done");
        repeat (2) tick();
        Freeze = 1'b1;
        freeze_reads = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            Step = (i < 40) && (((i / 5) % 2) == 1);
            if (RdEn === 1'b1) freeze_reads++;
        end
        chk("freeze_no_read", 32'(freeze_reads), 32'd0);
        chk("freeze_idx", 32'(IdxNib), 32'd1);
        chk("freeze_nibs", {16'h0, Nib3, Nib2, Nib1, Nib0}, 32'h1111);
        Freeze = 1'b0;
        mark_cyc = cyc;
        push(3'd2, 16'h2222, 1'b1, 2);

        // Step coincident with dwell expiry advances once.
        wait_rden(20);
        repeat (2) tick();
        Step = 1'b1;
        push(3'd3, 16'h3333, 1'b0, 6);
        push(3'd4, 16'h4444, 1'b0, 6);
        wait_done(40, "coincident_done");
        Step = 1'b0;

        // Reset during S_CAP discards the capture.
        push(3'd5, 16'h5555, 1'b0, 6);
        wait_rden(20);
        tick();
        Resetn = 1'b0;
        tick();
        chk("capreset_valid", 32'(Valid), 32'd0);
        chk("capreset_nibs", {16'h0, Nib3, Nib2, Nib1, Nib0}, 32'd0);
        chk("capreset_idx", 32'(IdxNib), 32'd0);
        chk("capreset_rden", 32'(RdEn), 32'd0);
        chk("capreset_dropped", 32'(dropped), 32'd1);
        tick();
        Resetn = 1'b1;
        mark_cyc = cyc;
        push(3'd0, 16'h0000, 1'b1, 1);
        wait_done(20, "post_reset_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
